// File: rtl/muldiv_seq.sv
// Sequential 32-bit signed multiply/divide: 32 shift-add or restoring steps, then sign fix.
// Optional macro MULDIV_DIV0_EXCP_EN short-circuits divide-by-zero straight to DONE with div0.
module muldiv_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned W    = 32;
  localparam int unsigned CW   = 6;
  localparam int unsigned ITER = 32;

  typedef enum logic [2:0] {IDLE, MULT, DIV, FIX, DONE} state_t;

  state_t          state, state_next;
  logic [CW-1:0]   cnt;
  logic [2*W-1:0]  acc;
  logic [W-1:0]    opnd;
  logic            op_q;
  logic            neg_res;
  logic            neg_rem;
  logic            load;
  logic            stepping;

  logic [W-1:0]    abs_a, abs_b;
  logic [W:0]      mul_sum;
  logic [W:0]      rem_sh, div_diff;
  logic [2*W-1:0]  mul_step, div_step, acc_step;
  logic [2*W-1:0]  fix_prod;
  logic [W-1:0]    fix_hi, fix_lo;

`ifdef MULDIV_DIV0_EXCP_EN
  logic            div0_hit;
`endif

  assign busy = (state != IDLE);

  // Next-state logic; abort overrides every transition out of a busy state.
  always_comb begin
    state_next = state;
    load       = 1'b0;
`ifdef MULDIV_DIV0_EXCP_EN
    div0_hit   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start && !abort) begin
`ifdef MULDIV_DIV0_EXCP_EN
          if (op && (b == '0)) begin
            state_next = DONE;
            div0_hit   = 1'b1;
          end else
`endif
          begin
            load       = 1'b1;
            state_next = op ? DIV : MULT;
          end
        end
      end
      MULT, DIV: if (cnt == CW'(ITER)) state_next = FIX;
      FIX:       state_next = DONE;
      DONE:      state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) state_next = IDLE;
  end

  // Datapath: unsigned iteration on magnitudes, signs restored in FIX.
  always_comb begin
    abs_a    = a[W-1] ? W'(-a) : a;
    abs_b    = b[W-1] ? W'(-b) : b;
    stepping = ((state == MULT) || (state == DIV)) && (cnt != CW'(ITER));

    mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
    mul_step = {mul_sum, acc[W-1:1]};

    rem_sh   = {acc[2*W-1:W], acc[W-1]};
    div_diff = rem_sh - {1'b0, opnd};
    div_step = div_diff[W] ? {rem_sh[W-1:0], acc[W-2:0], 1'b0}
                           : {div_diff[W-1:0], acc[W-2:0], 1'b1};
    acc_step = op_q ? div_step : mul_step;

    fix_prod = neg_res ? (2*W)'(-acc) : acc;
    if (op_q) begin
      fix_hi = neg_rem ? W'(-acc[2*W-1:W]) : acc[2*W-1:W];
      fix_lo = neg_res ? W'(-acc[W-1:0])   : acc[W-1:0];
    end else begin
      fix_hi = fix_prod[2*W-1:W];
      fix_lo = fix_prod[W-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      op_q    <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi      <= '0;
      lo      <= '0;
      done    <= 1'b0;
    end else begin
      done <= (state_next == DONE);
      if (load) begin
        acc     <= {{W{1'b0}}, abs_a};
        opnd    <= abs_b;
        op_q    <= op;
        neg_res <= a[W-1] ^ b[W-1];
        neg_rem <= a[W-1];
        cnt     <= '0;
      end else if (stepping) begin
        acc <= acc_step;
        cnt <= CW'(cnt + CW'(1));
      end
      if ((state == FIX) && !abort) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
    end
  end

`ifdef MULDIV_DIV0_EXCP_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) div0 <= 1'b0;
    else       div0 <= div0_hit && (state_next == DONE);
  end
`else
  assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed + random bench for muldiv_seq with a scoreboard of expected hi/lo/div0.
module tb_muldiv_seq;

  typedef struct packed {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        div0;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a, b;
  logic        abort;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int          nchecks = 0;
  int          nfails  = 0;
  exp_t        sb_q[$];
  logic [31:0] cur_hi, cur_lo;

  muldiv_seq dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b), .abort(abort),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nchecks++;
    assert (obs === expv) else begin
      nfails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic o, input logic [31:0] x, input logic [31:0] y);
    exp_t        e;
    longint      p;
    logic [63:0] pv;
    int          sx, sy, q, r;
    sx = x; sy = y;
    e.hi = cur_hi; e.lo = cur_lo; e.div0 = 1'b0;
    if (!o) begin
      p  = longint'(sx) * longint'(sy);
      pv = p;
      e.hi = pv[63:32]; e.lo = pv[31:0];
    end else if (y == 32'd0) begin
`ifdef MULDIV_DIV0_EXCP_EN
      e.div0 = 1'b1;
`else
      e.hi = x;
      e.lo = x[31] ? 32'h0000_0001 : 32'hFFFF_FFFF;
`endif
    end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      e.hi = 32'd0; e.lo = 32'h8000_0000;
    end else begin
      q = sx / sy; r = sx % sy;
      e.hi = r; e.lo = q;
    end
    return e;
  endfunction

  // Drive one operation, optionally poke a stray start mid-run, then score the result.
  task automatic run_op(input logic o, input logic [31:0] x, input logic [31:0] y, input int poke);
    exp_t e;
    int   n, lat;
    e = model(o, x, y);
    sb_q.push_back(e);
    cur_hi = e.hi; cur_lo = e.lo;
    lat = 34;
`ifdef MULDIV_DIV0_EXCP_EN
    if (o && y == 32'd0) lat = 0;
`endif
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 60) begin
      if (n == poke) begin start = 1'b1; op = ~o; a = 32'd99; b = 32'd3; end
      @(negedge clk);
      n++;
      start = 1'b0;
    end
    check("latency", 64'(n), 64'(lat));
    e = sb_q.pop_front();
    check("hi", 64'(hi), 64'(e.hi));
    check("lo", 64'(lo), 64'(e.lo));
    check("div0", 64'(div0), 64'(e.div0));
    // start during the DONE cycle must be dropped
    start = 1'b1; op = 1'b0; a = 32'd1; b = 32'd1;
    @(negedge clk);
    start = 1'b0;
    check("idle_after_done", 64'({busy, done}), 64'd0);
  endtask

  initial begin
    int          seen;
    logic [31:0] rx, ry;
    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0; abort = 1'b0;
    cur_hi = '0; cur_lo = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_div0", 64'(div0), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    // Directed arithmetic and boundary cases
    run_op(1'b0, 32'd7, 32'hFFFF_FFFD, -1);
    check("mul_hi_const", 64'(hi), 64'hFFFF_FFFF);
    check("mul_lo_const", 64'(lo), 64'hFFFF_FFEB);
    run_op(1'b1, 32'd100, 32'hFFFF_FFF9, -1);
    check("div_lo_const", 64'(lo), 64'hFFFF_FFF2);
    check("div_hi_const", 64'(hi), 64'd2);
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    check("ovf_lo_const", 64'(lo), 64'h8000_0000);
    run_op(1'b0, 32'h8000_0000, 32'h8000_0000, -1);
    run_op(1'b1, 32'd5, 32'd0, -1);
    run_op(1'b1, 32'hFFFF_FFFB, 32'd0, -1);
    run_op(1'b0, 32'hFFFF_FFFF, 32'd0, -1);

    // Randomised operands
    for (int i = 0; i < 8; i++) begin
      rx = $urandom; ry = $urandom;
      if (ry == 32'd0) ry = 32'd1;
      run_op(i[0], rx, ry, -1);
    end

    // Stray start during iterations: no effect, no second done
    run_op(1'b0, 32'd1234, 32'hFFFF_E9D2, 5);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("no_second_done", 64'(seen), 64'd0);

    // Abort at iteration 10
    start = 1'b1; op = 1'b1; a = 32'd1000; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_idle", 64'(busy), 64'd0);
    seen = 0;
    repeat (40) begin @(negedge clk); if (done) seen++; end
    check("abort_no_done", 64'(seen), 64'd0);
    check("abort_hi", 64'(hi), 64'(cur_hi));
    check("abort_lo", 64'(lo), 64'(cur_lo));

    // abort with start in IDLE stays idle
    abort = 1'b1; start = 1'b1; op = 1'b0; a = 32'd2; b = 32'd2;
    @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("abort_start_idle", 64'(busy), 64'd0);

    // Reset at iteration 20, then a fresh multiply
    start = 1'b1; op = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_outs", 64'({busy, done, div0, hi, lo}), 64'd0);
    cur_hi = '0; cur_lo = '0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    run_op(1'b0, 32'd3, 32'd4, -1);
    check("post_rst_lo", 64'(lo), 64'd12);

    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk and reset as the codebase does.
REQ-002 The block SHALL have no parameters; all datapath widths SHALL be fixed at 32 bits.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE.
REQ-006 op  input  1  0 = signed multiply, 1 = signed divide; sampled with start.
REQ-007 a  input  32  multiplicand or dividend; sampled with start.
REQ-008 b  input  32  multiplier or divisor; sampled with start.
REQ-009 abort  input  1  cancel the in-flight operation.
REQ-010 busy  output  1  high whenever the state is not IDLE.
REQ-011 done  output  1  one-cycle pulse; hi/lo valid.
REQ-012 div0  output  1  one-cycle pulse coincident with done on a divide by zero.
REQ-013 hi  output  32  product[63:32] or remainder.
REQ-014 lo  output  32  product[31:0] or quotient.

Function
REQ-015 The FSM SHALL have states IDLE, MULT, DIV, FIX and DONE; busy SHALL equal (state != IDLE).
REQ-016 In IDLE with start=1, the rising edge SHALL latch |a|, |b|, op and the result signs, clear the 6-bit iteration counter, and enter MULT (op=0) or DIV (op=1).
REQ-017 MULT SHALL perform one unsigned shift-add step per edge on the 64-bit accumulator, for 32 edges, then enter FIX.
REQ-018 DIV SHALL perform one restoring shift-subtract step per edge, for 32 edges, then enter FIX.
REQ-019 FIX SHALL apply sign correction, load hi/lo on its edge, and enter DONE; done SHALL be high for exactly the DONE cycle, after which the FSM SHALL return to IDLE.
REQ-020 Latency SHALL be fixed: done SHALL be high in the cycle after the 34th rising edge counted from the start-sampling edge (edge 0 samples start, edges 1-32 iterate, edge 33 is FIX, edge 34 enters DONE).
REQ-021 The multiply result SHALL be the exact 64-bit two's-complement product, with hi = [63:32] and lo = [31:0].
REQ-022 The divide quotient SHALL truncate toward zero; the remainder SHALL take the sign of the dividend.
REQ-023 0x80000000 / 0xFFFFFFFF SHALL give lo = 0x80000000 and hi = 0, with no flag raised.
REQ-024 start asserted while busy=1, including during the DONE cycle, SHALL be ignored and SHALL NOT be queued.
REQ-025 abort=1 in any non-IDLE state SHALL force IDLE on the next edge, with no done pulse and hi/lo unchanged; abort SHALL take priority over every other transition.
REQ-026 abort and start asserted together in IDLE SHALL leave the FSM in IDLE.
REQ-027 hi and lo SHALL change only on the FIX edge (or on reset) and SHALL hold their value until the next FIX.

Reset
REQ-028 reset SHALL asynchronously force state=IDLE, counter=0, accumulator=0, hi=0, lo=0, busy=0, done=0 and div0=0.
REQ-029 Reset asserted mid-operation SHALL discard the operation; the first start after reset deasserts SHALL behave as from power-up.

Configuration
REQ-030 Macro MULDIV_DIV0_EXCP_EN SHALL select divide-by-zero handling.
REQ-031 With MULDIV_DIV0_EXCP_EN defined, start with op=1 and b=0 SHALL move IDLE directly to DONE on the sampling edge, pulse done and div0 together, and leave hi/lo unchanged.
REQ-032 With MULDIV_DIV0_EXCP_EN undefined, div0 SHALL be tied to 0 and a divide by zero SHALL run the full latency, giving hi = a and lo = 0xFFFFFFFF if a >= 0, otherwise lo = 0x00000001.

Verification
REQ-033 Multiply: a=7, b=0xFFFFFFFD, op=0 -> done at edge 34 after start, hi=0xFFFFFFFF, lo=0xFFFFFFEB, busy low in the following cycle.
REQ-034 Divide: a=100, b=0xFFFFFFF9 -> lo=0xFFFFFFF2, hi=2; a=0xFFFFFFF9, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-035 Overflow: a=0x80000000, b=0xFFFFFFFF, op=1 -> lo=0x80000000, hi=0, div0=0.
REQ-036 Divide by zero: a=5, b=0 -> with the macro, done and div0 high one cycle after start with hi/lo unchanged; without the macro, done at edge 34 with hi=5, lo=0xFFFFFFFF, div0=0.
REQ-037 Abort and ignored start: abort at iteration 10 -> IDLE next edge, no done, hi/lo unchanged; start during iterations -> no effect on the result and no second done.
REQ-038 Reset mid-operation: reset pulsed at iteration 20 -> all outputs 0 immediately; a new multiply 3*4 then gives hi=0, lo=12.
